mux_scan_n: RTL



---
 rtl/mux_scan_n_pkg.sv | 13 +
 rtl/mux_scan_n_if.sv | 29 ++
 rtl/mux_scan_n_rr_ptr.sv | 34 +++
 rtl/mux_scan_n.sv | 91 +++++++++
 4 files changed

// File: rtl/mux_scan_n_pkg.sv
// Shared types and helpers for the scanning N-channel mux.
package mux_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 8;

   typedef enum logic [1:0] {S_MAN, S_AUTO, S_DRAIN} state_e;

   function automatic int next_ch(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Channel/handshake bundle between the stream sources, the mux and its consumer.
interface mux_scan_n_if
   import mux_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
);
   localparam int SW = $clog2(N);

   logic [N-1:0][W-1:0] in_data;
   logic [N-1:0]        in_valid;
   logic [N-1:0]        in_ready;
   logic                mode;
   logic [SW-1:0]       sel;
   logic [W-1:0]        out_data;
   logic                out_valid;
   logic                out_ready;
   logic [SW-1:0]       out_ch;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface

// File: rtl/mux_scan_n_rr_ptr.sv
// Round-robin channel pointer for auto-scan mode.
// MUX_SCAN_SKIP_EN: pointer also steps past idle channels instead of waiting.
module rr_ptr
   import mux_pkg::*;
#(
   parameter  int N  = N_DEF,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          auto_en,
   input  logic          load,
   input  logic [N-1:0]  in_valid,
   output logic [SW-1:0] ptr
);
   logic adv;

`ifdef MUX_SCAN_SKIP_EN
   // Either the channel transfers or it is idle; both move the pointer on.
   assign adv = auto_en && load;
`else
   assign adv = auto_en && load && in_valid[ptr];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (clear)
         ptr <= '0;
      else if (adv)
         ptr <= SW'(next_ch(int'(ptr), N));
   end
endmodule

// File: rtl/mux_scan_n.sv
// N-channel W-bit mux with registered valid/ready output, manual or round-robin select.
// MUX_SCAN_SKIP_EN (in rr_ptr): auto scan skips idle channels.
module mux_scan_n
   import mux_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int W  = W_DEF,
   localparam int SW = $clog2(N)
) (
   input logic         clk,
   input logic         rst_n,
   mux_scan_n_if.slave bus
);
   localparam logic [SW:0] N_L = (SW+1)'(N);

   state_e        state_q, state_d, st;
   logic          boot_q;
   logic [SW-1:0] ptr, ch_idx, ch_q;
   logic          cur_ok, load, accept, pop, valid_q;
   logic [N-1:0]  ready;
   logic [W-1:0]  mux_data, data_q;

   // Until the first edge after reset the state simply tracks mode.
   assign st = boot_q ? (bus.mode ? S_AUTO : S_MAN) : state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_MAN;
         boot_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         boot_q  <= 1'b0;
      end
   end

   always_comb begin
      state_d = st;
      case (st)
         S_MAN:   if (bus.mode)  state_d = S_DRAIN;
         S_AUTO:  if (!bus.mode) state_d = S_DRAIN;
         default: if (!valid_q)  state_d = bus.mode ? S_AUTO : S_MAN;
      endcase
   end

   assign load   = rst_n && (!valid_q || bus.out_ready) && (st != S_DRAIN);
   assign ch_idx = (st == S_AUTO) ? ptr : bus.sel;
   assign cur_ok = (st == S_AUTO) || ((st == S_MAN) && ({1'b0, bus.sel} < N_L));

   always_comb begin
      ready    = '0;
      mux_data = '0;
      for (int c = 0; c < N; c++) begin
         if (ch_idx == SW'(c)) begin
            ready[c] = load && cur_ok;
            mux_data = bus.in_data[c];
         end
      end
   end

   assign accept = |(ready & bus.in_valid);
   assign pop    = valid_q && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         data_q  <= mux_data;
         ch_q    <= ch_idx;
      end else if (pop) begin
         valid_q <= 1'b0;
      end
   end

   rr_ptr #(.N(N)) u_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (st == S_DRAIN),
      .auto_en  (st == S_AUTO),
      .load     (load),
      .in_valid (bus.in_valid),
      .ptr      (ptr)
   );

   assign bus.in_ready  = ready;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.out_ch    = ch_q;
endmodule
